// File: rtl/riscv_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_access
// Purpose  : RV32 load/store controller for a word-wide BRAM; sub-word stores
//            use read-modify-write. Optional macro RISCV_MEM_ACCESS_ALIGN_CHECK_EN
//            turns misaligned halfword/word accesses into error responses.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_access #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   mem_write_en,
  output logic [ADDR_LENGTH-1:0] mem_waddr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic [ADDR_LENGTH-1:0] mem_raddr,
  input  logic [WORD_LENGTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_we;
  logic [2:0]             r_funct3;
  logic [1:0]             r_off;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [WORD_LENGTH-1:0] r_wdata;
  logic [WORD_LENGTH-1:0] r_merge;
  logic [WORD_LENGTH-1:0] r_rdata;
  logic                   r_err;

  logic                   w_illegal;
  logic                   w_misaligned;
  logic                   w_reject;
  logic                   w_is_sw;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [WORD_LENGTH-1:0] w_load;
  logic [WORD_LENGTH-1:0] w_merge;
  logic                   w_unused_addr;

  // High address bits are dropped on purpose: accesses wrap modulo BRAM size.
  assign w_unused_addr = ^req_addr[31:ADDR_LENGTH+2];

  assign w_illegal = req_we ? (req_funct3 > 3'd2)
                            : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));

`ifdef RISCV_MEM_ACCESS_ALIGN_CHECK_EN
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_reject = w_illegal | w_misaligned;
  assign w_is_sw  = r_we && (r_funct3[1:0] == 2'b10);

  // Lane extraction for loads; halfwords key off bit 1 only.
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0:    w_byte = mem_dout[7:0];
      2'd1:    w_byte = mem_dout[15:8];
      2'd2:    w_byte = mem_dout[23:16];
      default: w_byte = mem_dout[31:24];
    endcase
    w_half = r_off[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'h000000, w_byte};
      3'd5:    w_load = {16'h0000, w_half};
      default: w_load = mem_dout;
    endcase
  end

  always_comb begin
    w_merge = mem_dout;
    if (r_funct3[1:0] == 2'b00) begin
      w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = w_reject ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: w_next = (r_we && !w_is_sw) ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_addr   <= req_addr[ADDR_LENGTH+1:2];
            r_wdata  <= req_wdata;
            r_err    <= w_reject;
            r_rdata  <= '0;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rdata <= w_load;
          end else begin
            r_merge <= w_merge;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_raddr  = r_addr;
  assign mem_waddr  = r_addr;

  // Gating with rst lets a reset landing mid-request cancel the pending write.
  assign mem_write_en = !rst && (((r_state == S_ACCESS) && w_is_sw) || (r_state == S_WRITE));
  assign mem_wdata    = (r_state == S_WRITE)             ? r_merge :
                        ((r_state == S_ACCESS) && r_we)  ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_access
// Purpose  : Self-checking bench for riscv_mem_access with a word-level memory
//            model and per-cycle expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [13:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [13:0] mem_raddr;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  riscv_mem_access #(.WORD_LENGTH(32), .ADDR_LENGTH(14)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_write_en(mem_write_en), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_dout(mem_dout)
  );

  logic [31:0] bram [0:16383];
  assign mem_dout = bram[mem_raddr];
  always @(posedge clk) if (mem_write_en) bram[mem_waddr] <= mem_wdata;

  logic [31:0] model_mem [0:16383];

  typedef struct {
    bit          ready;
    bit          rvalid;
    bit          err;
    bit          we;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [13:0] waddr;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_resp = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit ready, input bit rvalid, input bit err, input bit we,
                              input logic [31:0] rdata, input logic [31:0] wdata,
                              input logic [13:0] waddr);
    exp_t r;
    r.ready = ready; r.rvalid = rvalid; r.err = err; r.we = we;
    r.rdata = rdata; r.wdata = wdata; r.waddr = waddr;
    return r;
  endfunction

  always @(negedge clk) begin
    if (resp_valid) begin
      last_rdata = resp_rdata;
      last_err   = resp_err;
      n_resp++;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("resp_valid", 32'(resp_valid), 32'(e.rvalid));
      chk("mem_write_en", 32'(mem_write_en), 32'(e.we));
      if (e.we) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(e.waddr));
        chk("mem_wdata", mem_wdata, e.wdata);
      end
      if (e.rvalid) begin
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Reference: the RISC-V load/store rules applied to a flat word array.
  function automatic void predict(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output bit err, output int lat,
                                  output logic [31:0] rdata, output bit wr,
                                  output logic [31:0] nw);
    int unsigned idx, off, b, h, sh, mask, w;
    idx = 32'(addr[15:2]);
    off = 32'(addr[1:0]);
    w   = model_mem[idx];
    err = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
`ifdef RISCV_MEM_ACCESS_ALIGN_CHECK_EN
    if (!err && (off % (1 << f3[1:0])) != 0) err = 1'b1;
`endif
    rdata = 32'h0; wr = 1'b0; nw = w; lat = 1;
    if (!err) begin
      b  = (w >> (8 * off)) & 32'hFF;
      sh = 16 * (off / 2);
      h  = (w >> sh) & 32'hFFFF;
      if (!we) begin
        lat = 2;
        case (f3)
          3'd0:    rdata = (b >= 128) ? b + 32'hFFFFFF00 : b;
          3'd1:    rdata = (h >= 32768) ? h + 32'hFFFF0000 : h;
          3'd4:    rdata = b;
          3'd5:    rdata = h;
          default: rdata = w;
        endcase
      end else begin
        wr = 1'b1;
        if (f3 == 3'd2) begin
          nw = wd; lat = 2;
        end else if (f3 == 3'd0) begin
          mask = 32'hFF << (8 * off);
          nw = (w & ~mask) | ((wd & 32'hFF) << (8 * off)); lat = 3;
        end else begin
          mask = 32'hFFFF << sh;
          nw = (w & ~mask) | ((wd & 32'hFFFF) << sh); lat = 3;
        end
      end
    end
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int gap);
    bit          err, wr;
    int          lat;
    logic [31:0] rdata, nw;
    logic [13:0] widx;
    predict(we, f3, addr, wd, err, lat, rdata, wr, nw);
    widx = addr[15:2];
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 14'h0));
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= lat; k++)
      q.push_back(mk(1'b0, k == lat, err, wr && (k == lat - 1), rdata, nw, widx));
    if (wr) model_mem[32'(widx)] = nw;
    repeat (lat) begin @(posedge clk); #1; end
    repeat (gap) begin
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 14'h0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int resp_before;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_write_en", 32'(mem_write_en), 32'd0);
    chk("rst mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
    chk("sw resp_err", 32'(last_err), 32'd0);
    chk("sw bram[4]", bram[4], 32'hDEADBEEF);

    do_req(1'b1, 3'd2, 32'h20, 32'h80FF7F01, 0);
    do_req(1'b0, 3'd0, 32'h23, 32'h0, 0);
    chk("lb 0x23", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h23, 32'h0, 0);
    chk("lbu 0x23", last_rdata, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h22, 32'h0, 0);
    chk("lh 0x22", last_rdata, 32'hFFFF80FF);
    do_req(1'b0, 3'd5, 32'h20, 32'h0, 0);
    chk("lhu 0x20", last_rdata, 32'h00007F01);

    do_req(1'b1, 3'd2, 32'h40, 32'h11223344, 0);
    do_req(1'b1, 3'd0, 32'h41, 32'h000000AA, 0);
    chk("sb merge", bram[16], 32'h1122AA44);
    do_req(1'b1, 3'd1, 32'h42, 32'h0000BEEF, 0);
    chk("sh merge", bram[16], 32'hBEEFAA44);

    do_req(1'b0, 3'd2, 32'h42, 32'h0, 0);
`ifdef RISCV_MEM_ACCESS_ALIGN_CHECK_EN
    chk("lw misaligned err", 32'(last_err), 32'd1);
    chk("lw misaligned rdata", last_rdata, 32'h0);
`else
    chk("lw unaligned rdata", last_rdata, 32'hBEEFAA44);
`endif
    do_req(1'b0, 3'd3, 32'h40, 32'h0, 0);
    chk("illegal funct3 err", 32'(last_err), 32'd1);

    // SB aborted by reset while the merged word is being written.
    resp_before = n_resp;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h40; req_wdata = 32'h55;
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 14'h0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 14'h0));
    @(posedge clk); #1;
    rst = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 14'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 14'h0));
    @(posedge clk); #1;
    chk("abort bram", bram[16], 32'hBEEFAA44);
    chk("abort no resp", 32'(n_resp), 32'(resp_before));

    for (int i = 0; i < 32; i++) begin
      a = $urandom;
      a[15:0] = 16'(i * 4);
      do_req(1'b1, 3'd2, a, $urandom, 0);
    end
    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      a[15:7] = 9'h0;
      do_req(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
